// File: rtl/chu_gpi_db.sv
// chu_gpi_db: debounced general-purpose input slot for the MMIO bus.
// Each of the W external lines is synchronized with two flops and debounced
// by a per-bit counter. Enabled rising/falling flips of the debounced value
// are latched in a sticky write-1-to-clear EDGE register. irq is high while
// any captured bit is set.
//
// Ports:
//   clk      - system clock
//   reset    - synchronous active-high reset
//   cs       - slot select
//   read     - read strobe (reads have no side effects)
//   write    - write strobe, qualified by cs
//   addr     - register word index: 0 SYNC, 1 DB, 2 EDGE, 3 RISE_EN, 4 FALL_EN
//   wr_data  - write data (bits >= W ignored)
//   rd_data  - combinational read data selected by addr (bits >= W are 0)
//   din      - asynchronous external inputs
//   irq      - registered OR of the EDGE register
module chu_gpi_db #(
    parameter int unsigned W         = 16,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          read,
    input  logic          write,
    input  logic [4:0]    addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    input  logic [W-1:0]  din,
    output logic          irq
);

    localparam int unsigned    CNT_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    localparam logic [4:0] ADDR_SYNC = 5'd0;
    localparam logic [4:0] ADDR_DB   = 5'd1;
    localparam logic [4:0] ADDR_EDGE = 5'd2;
    localparam logic [4:0] ADDR_RISE = 5'd3;
    localparam logic [4:0] ADDR_FALL = 5'd4;

    logic [W-1:0]     s1_q;
    logic [W-1:0]     s2_q;
    logic [W-1:0]     db_q,      db_d;
    logic [W-1:0]     edge_q,    edge_d;
    logic [W-1:0]     rise_en_q, rise_en_d;
    logic [W-1:0]     fall_en_q, fall_en_d;
    logic [CNT_W-1:0] cnt_q [W];
    logic [CNT_W-1:0] cnt_d [W];
    logic             irq_q;

    logic [W-1:0]     flip_c;
    logic [W-1:0]     clr_c;
    logic             wr_en_c;
    logic             unused_c;

    // The read strobe and wr_data bits above W carry no function here.
    assign unused_c = read ^ (^wr_data);

    assign wr_en_c = cs && write;

    // Per-bit debounce: any matching cycle restarts the count; the bit flips
    // on the DB_CYCLES-th consecutive mismatch.
    always_comb begin
        flip_c = '0;
        for (int i = 0; i < W; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                flip_c[i] = 1'b1;
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        db_d = db_q ^ flip_c;
    end

    // Edge capture and control registers; on a flip s2 already holds the new
    // debounced value, so it tells rising from falling. Set beats clear.
    always_comb begin
        clr_c     = '0;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        if (wr_en_c && (addr == ADDR_EDGE)) begin
            clr_c = wr_data[W-1:0];
        end
        if (wr_en_c && (addr == ADDR_RISE)) begin
            rise_en_d = wr_data[W-1:0];
        end
        if (wr_en_c && (addr == ADDR_FALL)) begin
            fall_en_d = wr_data[W-1:0];
        end
        edge_d = (edge_q & ~clr_c)
               | (flip_c &  s2_q & rise_en_q)
               | (flip_c & ~s2_q & fall_en_q);
    end

    // Read mux
    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_SYNC: rd_data = 32'(s2_q);
            ADDR_DB:   rd_data = 32'(db_q);
            ADDR_EDGE: rd_data = 32'(edge_q);
            ADDR_RISE: rd_data = 32'(rise_en_q);
            ADDR_FALL: rd_data = 32'(fall_en_q);
            default:   rd_data = '0;
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            edge_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= din;
            s2_q      <= s1_q;
            db_q      <= db_d;
            edge_q    <= edge_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            irq_q     <= |edge_q;
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign irq = irq_q;

endmodule

// File: doc/chu_gpi_db.md
# chu_gpi_db

Debounced general-purpose input slot for the MMIO bus. It is the input-side counterpart to the GPO slot and reads W external lines, typically switches and pushbuttons. Each line passes through a 2-FF synchronizer and a per-bit debounce counter. The block latches enabled rising and falling edges into a sticky capture register, which software clears by writing 1s to it. An interrupt-level output is raised while any captured bit is set.

## Interface

Parameters:
- W, 16: number of input lines (1..32).
- DB_CYCLES, 1_000_000: consecutive mismatch cycles needed before the debounced bit flips (≥2). Counter width is $clog2(DB_CYCLES).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- cs  in  1  slot select.
- read  in  1  read strobe. Reads have no side effects.
- write  in  1  write strobe. A write is performed only when cs && write.
- addr  in  5  register index within the slot.
- wr_data  in  32  write data.
- rd_data  out  32  read data, a combinational mux on addr. Upper bits beyond W are 0.
- din  in  W  asynchronous external inputs.
- irq  out  1  registered; equals |edge_reg.

## Operation

Register map (word index):
- 0 SYNC (RO): synchronized raw input s2.
- 1 DB (RO): debounced value db_reg.
- 2 EDGE (R/W1C): sticky edge capture. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- 3 RISE_EN (R/W): per-bit enable for rising-edge capture.
- 4 FALL_EN (R/W): per-bit enable for falling-edge capture.
- 5..31: read 0; writes are ignored.

Synchronizer:
- s1 <= din; s2 <= s1.

Debounce, per bit i:
- If s2[i] == db_reg[i]: cnt[i] <= 0.
- Else if cnt[i] == DB_CYCLES-1: db_reg[i] <= s2[i] and cnt[i] <= 0.
- Else: cnt[i] <= cnt[i]+1.
- A single matching cycle restarts the count, so a glitch shorter than DB_CYCLES never propagates.

Edge capture, per bit:
- rise = flip && s2 && RISE_EN.
- fall = flip && !s2 && FALL_EN.
- Next edge_reg = (edge_reg & ~clr) | rise | fall, where clr = wr_data[W-1:0] when a write to addr 2 occurs, else 0.
- If a clear and a new edge hit the same bit in the same cycle, the set wins.
- Changing RISE_EN or FALL_EN never alters edge_reg already captured.

Reset values (all synchronous):
- s1, s2, db_reg, cnt, edge_reg, RISE_EN, FALL_EN, irq = 0.
- rd_data follows addr from these zeroed registers.
- Reset mid-debounce discards the count.
- After reset, an input held high is accepted as a rising flip after the full DB_CYCLES, but it is captured only if RISE_EN has been set by then.

## Timing

- din change sampled at edge k:
  - s2 changes at edge k+1.
  - db_reg and edge_reg update at edge k+1+DB_CYCLES.
  - irq updates at edge k+2+DB_CYCLES.
- Register writes take effect at the edge where cs && write is sampled high. The new value is readable in the next cycle.
- rd_data has zero-cycle latency from addr; the bus samples it in the same cycle as read.
- Bits ≥ W of wr_data are ignored, and bits ≥ W of every read are 0.
- Each bit's debounce runs independently. Several bits flipping in the same cycle all capture in that cycle.

## Test plan

Bench settings: W=4, DB_CYCLES=4.

- **Reset:** assert reset for 2 cycles with din=4'hF. Then read addr 0..4 → 0. Confirm irq=0, and SYNC=4'hF two cycles after reset drops.
- **Clean rise:** write RISE_EN=4'h1, then drive din[0] 0→1 at edge k. DB[0]=1 and EDGE=4'h1 at edge k+5, irq=1 at edge k+6. FALL_EN=0, so dropping din[0] and waiting ≥6 cycles leaves EDGE=4'h1.
- **Glitch rejection:** with din[1] low, pulse it high for 3 cycles, then low. DB[1] stays 0. Repeat with a 4-cycle-wide pulse → DB[1] flips to 1.
- **W1C and set-wins collision:**
  - With EDGE=4'h3, write 4'h1 to addr 2 → EDGE=4'h2, irq stays 1.
  - Arrange a bit-1 flip on the same edge as a write of 4'h2 → EDGE bit1 stays 1.
  - Write 4'h2 again → EDGE=0 and irq=0 one cycle later.
- **Mask and reserved addresses:**
  - With FALL_EN=4'h8 and RISE_EN=0, toggling din[3] 1→0 captures EDGE=4'h8. Toggling din[2] 1→0 captures nothing.
  - A write to addr 7 leaves every register unchanged, and a read of addr 7 returns 0.
- **Reset mid-count:** start a din[0] change, then assert reset after 2 mismatch cycles. DB stays 0. After release, DB[0]=1 only once a fresh 4-cycle stable window has completed after the synchronizer refills.
